// File: rtl/led_pkg.sv
// Shared definitions for the LED animation path: sequencer states, speed codes
// and the default pass length used by both the sequencer and the decoder table.
package led_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Speed code is a left-shift of the base divider: period = DIV << speed.
  localparam logic [1:0] SPEED_X1 = 2'd0;
  localparam logic [1:0] SPEED_X2 = 2'd1;
  localparam logic [1:0] SPEED_X4 = 2'd2;
  localparam logic [1:0] SPEED_X8 = 2'd3;

  localparam int LAST_STEP = 29;
  localparam int STEP_W    = 5;

endpackage

// File: rtl/led_prescaler.sv
// Animation-rate prescaler: counts while enabled and flags a tick once the count
// reaches (DIV << speed) - 1, then restarts from zero.
module led_prescaler
  import led_pkg::*;
#(
  parameter int DIV   = 5000000,
  parameter int CNT_W = 29
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [1:0] speed,
  output logic       tick
);

  localparam logic [CNT_W-1:0] DIV_V = CNT_W'(DIV);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period_m1;

  assign period_m1 = (DIV_V << speed) - CNT_W'(1);

  // >= rather than == so a speed decrease mid-step lands on the next cycle
  // instead of waiting for the counter to wrap.
  assign tick = en && (cnt >= period_m1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      if (tick) cnt <= '0;
      else      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_step_seq.sv
// Step sequencer for the LED animation: run/hold/idle control, loop or one-shot,
// forward or reverse stepping, and an end-of-pass pulse. All outputs registered.
module led_step_seq
  import led_pkg::*;
#(
  parameter int DIV   = 5000000,
  parameter int LAST  = LAST_STEP,
  parameter int CNT_W = 29
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop,
  input  logic              rev,
  input  logic [1:0]        speed,
  output logic [STEP_W-1:0] step,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [STEP_W-1:0] LAST_V = STEP_W'(LAST);

  state_t state;
  logic   tick;
  logic   pre_clr;

  // The prescaler sits at zero whenever the sequencer is idle or (re)starting.
  assign pre_clr = stop || start || (state == ST_IDLE);

  led_prescaler #(
    .DIV   (DIV),
    .CNT_W (CNT_W)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clr   (pre_clr),
    .en    (state == ST_RUN),
    .speed (speed),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      step       <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (stop) begin
        state <= ST_IDLE;
        step  <= '0;
        busy  <= 1'b0;
      end else if (start) begin
        state <= ST_RUN;
        step  <= rev ? LAST_V : '0;
        busy  <= 1'b1;
      end else begin
        case (state)
          ST_RUN: begin
            if (pause) state <= ST_HOLD;
            if (tick) begin
              if (!rev && step < LAST_V) begin
                step <= step + STEP_W'(1);
              end else if (rev && step != '0) begin
                step <= step - STEP_W'(1);
              end else begin
                // End of pass: a one-shot finish goes idle even if paused now.
                frame_done <= 1'b1;
                step       <= (loop && rev) ? LAST_V : '0;
                if (!loop) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                end
              end
            end
          end
          ST_HOLD: begin
            if (pause) state <= ST_RUN;
          end
          default: begin
            state <= ST_IDLE;
            step  <= '0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
